// File: rtl/mem_access_seq_pkg.sv
// Shared types and default sizing for the memory access sequencer.
package mem_access_seq_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int WAIT_W = 4;

    localparam logic [WAIT_W-1:0] WAIT_RST = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_e;

endpackage

// File: rtl/mem_access_seq_if.sv
// RAM-side bus of the access sequencer: the sequencer is master, the RAM is slave.
interface mem_access_seq_if #(
    parameter int ADDR_W = mem_access_seq_pkg::ADDR_W,
    parameter int DATA_W = mem_access_seq_pkg::DATA_W
);

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_cs,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_access_seq_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = mem_access_seq_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count register: reset, then clear, then increment unless already at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_seq.sv
// Single-port RAM access sequencer: IDLE -> SETUP -> ACCESS (W+1 cycles) -> DONE.
module mem_access_seq #(
    parameter int                                     ADDR_W   = mem_access_seq_pkg::ADDR_W,
    parameter int                                     DATA_W   = mem_access_seq_pkg::DATA_W,
    parameter int                                     CNT_W    = mem_access_seq_pkg::CNT_W,
    parameter logic [mem_access_seq_pkg::WAIT_W-1:0]  WAIT_RST = mem_access_seq_pkg::WAIT_RST
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    req,
    input  logic                                    r_wb,
    input  logic [ADDR_W-1:0]                       addr,
    input  logic [DATA_W-1:0]                       wdata,
    input  logic                                    cfg_wait_en,
    input  logic [mem_access_seq_pkg::WAIT_W-1:0]   cfg_wait,
    input  logic                                    clr_cnt,
    mem_access_seq_if.master                        mem,
    output logic                                    busy,
    output logic                                    done,
    output logic [DATA_W-1:0]                       rdata,
    output logic [CNT_W-1:0]                        rd_cnt,
    output logic [CNT_W-1:0]                        wr_cnt
);

    import mem_access_seq_pkg::*;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                rwb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                capture;
    logic                rd_inc;
    logic                wr_inc;

    // Next-state logic; registered outputs are decoded from the next state so they track state_q exactly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_wait_en) begin
                    wait_d = cfg_wait;
                end
                if (req) begin
                    state_d = SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = wait_q;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    capture = rwb_q;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        cs_d   = (state_d == ACCESS);
        we_d   = cs_d & ~rwb_q;
        done_d = (state_d == DONE);
    end

    // State, request latches, wait setting and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= WAIT_RST;
            rwb_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (accept) begin
                rwb_q   <= r_wb;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (capture) begin
                rdata_q <= mem.mem_rdata;
            end
        end
    end

    assign rd_inc = (state_q == DONE) &  rwb_q;
    assign wr_inc = (state_q == DONE) & ~rwb_q;

    sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (rd_inc),
        .clr   (clr_cnt),
        .count (rd_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (wr_inc),
        .clr   (clr_cnt),
        .count (wr_cnt)
    );

    assign mem.mem_cs    = cs_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign rdata         = rdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: vector table plus hand-written multi-cycle sequences.
// A second instance with 2-bit statistics shares all inputs so counter saturation is reached quickly.
module tb_mem_access_seq;

    logic        clock;
    logic        reset;
    logic        req;
    logic        r_wb;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        cfg_wait_en;
    logic [3:0]  cfg_wait;
    logic        clr_cnt;
    logic        busy, done;
    logic [7:0]  rdata;
    logic [15:0] rd_cnt, wr_cnt;
    logic        s_busy, s_done;
    logic [7:0]  s_rdata;
    logic [1:0]  s_rd_cnt, s_wr_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mem_access_seq_if #(.ADDR_W(12), .DATA_W(8)) m_if ();
    mem_access_seq_if #(.ADDR_W(12), .DATA_W(8)) s_if ();

    mem_access_seq dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .r_wb        (r_wb),
        .addr        (addr),
        .wdata       (wdata),
        .cfg_wait_en (cfg_wait_en),
        .cfg_wait    (cfg_wait),
        .clr_cnt     (clr_cnt),
        .mem         (m_if),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt)
    );

    mem_access_seq #(.CNT_W(2)) dut_sat (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .r_wb        (r_wb),
        .addr        (addr),
        .wdata       (wdata),
        .cfg_wait_en (cfg_wait_en),
        .cfg_wait    (cfg_wait),
        .clr_cnt     (clr_cnt),
        .mem         (s_if),
        .busy        (s_busy),
        .done        (s_done),
        .rdata       (s_rdata),
        .rd_cnt      (s_rd_cnt),
        .wr_cnt      (s_wr_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rwb;
        logic [11:0] a;
        logic [7:0]  wd;
        logic        wen;
        logic [3:0]  wv;
        logic [7:0]  mrd;
        int unsigned w;
        logic [7:0]  exp_rdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
        logic [1:0]  exp_srd;
        logic [1:0]  exp_swr;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_mem_rdata(input logic [7:0] v);
        m_if.mem_rdata = v;
        s_if.mem_rdata = v;
    endtask

    // Issues one request at the current negedge and follows it through DONE and back to IDLE.
    task automatic run_access(input string tag, input logic rwb, input logic [11:0] a,
                              input logic [7:0] wd, input logic wen, input logic [3:0] wv,
                              input logic [7:0] mrd, input int unsigned exp_w,
                              input bit perturb, input bit clr_at_done);
        int unsigned edges;
        int unsigned cs_cycles;
        int unsigned bad_addr;
        int unsigned bad_we;
        int unsigned bad_wd;
        bit          seen_done;
        edges = 0; cs_cycles = 0; bad_addr = 0; bad_we = 0; bad_wd = 0; seen_done = 1'b0;
        req = 1'b1; r_wb = rwb; addr = a; wdata = wd;
        cfg_wait_en = wen; cfg_wait = wv;
        set_mem_rdata(mrd);
        while (!seen_done && edges < 40) begin
            @(negedge clock);
            edges++;
            if (edges == 1) begin
                req = 1'b0;
                cfg_wait_en = 1'b0;
                check({tag, "_setup_busy"}, 32'(busy), 32'd1);
                check({tag, "_setup_cs"}, 32'(m_if.mem_cs), 32'd0);
                check({tag, "_setup_addr"}, 32'(m_if.mem_addr), 32'(a));
                if (perturb) begin
                    addr  = 12'h777;
                    r_wb  = ~rwb;
                    wdata = ~wd;
                end
            end
            if (m_if.mem_cs) begin
                cs_cycles++;
                if (m_if.mem_addr !== a) bad_addr++;
                if (m_if.mem_we !== ~rwb) bad_we++;
                if (!rwb && (m_if.mem_wdata !== wd)) bad_wd++;
                if (perturb) begin
                    cfg_wait_en = 1'b1;
                    cfg_wait    = 4'd0;
                end
            end
            if (done) seen_done = 1'b1;
        end
        cfg_wait_en = 1'b0;
        check({tag, "_done_edges"}, 32'(edges), 32'(exp_w + 3));
        check({tag, "_cs_cycles"}, 32'(cs_cycles), 32'(exp_w + 1));
        check({tag, "_bad_addr"}, 32'(bad_addr), 32'd0);
        check({tag, "_bad_we"}, 32'(bad_we), 32'd0);
        check({tag, "_bad_wdata"}, 32'(bad_wd), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_cs"}, 32'(m_if.mem_cs), 32'd0);
        clr_cnt = clr_at_done;
        @(negedge clock);
        clr_cnt = 1'b0;
        check({tag, "_post_done"}, 32'(done), 32'd0);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned edges;
        int unsigned n_done;
        int unsigned first_at;
        int unsigned second_at;

        //           rwb   addr     wdata  wen   wait   mrd    W   rdata  rd     wr     srd   swr
        vecs[0] = '{1'b1, 12'h0A5, 8'h00, 1'b0, 4'd0,  8'h3C, 2,  8'h3C, 16'd1, 16'd0, 2'd1, 2'd0};
        vecs[1] = '{1'b0, 12'hFFF, 8'h81, 1'b1, 4'd0,  8'h55, 0,  8'h3C, 16'd1, 16'd1, 2'd1, 2'd1};
        vecs[2] = '{1'b1, 12'h123, 8'h00, 1'b1, 4'd5,  8'hA7, 5,  8'hA7, 16'd2, 16'd1, 2'd2, 2'd1};
        vecs[3] = '{1'b0, 12'h000, 8'h5A, 1'b0, 4'hF,  8'hFF, 5,  8'hA7, 16'd2, 16'd2, 2'd2, 2'd2};
        vecs[4] = '{1'b1, 12'h800, 8'h00, 1'b1, 4'hF,  8'h01, 15, 8'h01, 16'd3, 16'd2, 2'd3, 2'd2};

        reset = 1'b1; req = 1'b0; r_wb = 1'b0; addr = '0; wdata = '0;
        cfg_wait_en = 1'b0; cfg_wait = '0; clr_cnt = 1'b0;
        set_mem_rdata(8'h00);
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cs", 32'(m_if.mem_cs), 32'd0);
        check("rst_we", 32'(m_if.mem_we), 32'd0);
        check("rst_addr", 32'(m_if.mem_addr), 32'd0);
        check("rst_wdata", 32'(m_if.mem_wdata), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst_sat_busy", 32'(s_busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i].rwb, vecs[i].a, vecs[i].wd, vecs[i].wen,
                       vecs[i].wv, vecs[i].mrd, vecs[i].w, 1'b0, 1'b0);
            check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_rd_cnt", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_sat_rd", i), 32'(s_rd_cnt), 32'(vecs[i].exp_srd));
            check($sformatf("vec%0d_sat_wr", i), 32'(s_wr_cnt), 32'(vecs[i].exp_swr));
            check($sformatf("vec%0d_sat_rdata", i), 32'(s_rdata), 32'(vecs[i].exp_rdata));
        end

        // W=3 loaded at acceptance; req/addr/r_wb/wdata change after sampling; cfg load during ACCESS ignored.
        run_access("hold", 1'b1, 12'h2B4, 8'h00, 1'b1, 4'd3, 8'h9E, 3, 1'b1, 1'b0);
        check("hold_rdata", 32'(rdata), 32'h9E);
        check("hold_rd_cnt", 32'(rd_cnt), 32'd4);
        check("hold_wr_cnt", 32'(wr_cnt), 32'd2);
        run_access("wkeep", 1'b1, 12'h0C3, 8'h00, 1'b0, 4'd0, 8'h42, 3, 1'b0, 1'b0);
        check("wkeep_rdata", 32'(rdata), 32'h42);
        check("wkeep_rd_cnt", 32'(rd_cnt), 32'd5);
        check("wkeep_sat_rd", 32'(s_rd_cnt), 32'd3);

        // req held high: two back-to-back reads, done at edge W+3 and again W+4 later.
        req = 1'b1; r_wb = 1'b1; addr = 12'h010; wdata = 8'h00; set_mem_rdata(8'h11);
        edges = 0; n_done = 0; first_at = 0; second_at = 0;
        while (n_done < 2 && edges < 40) begin
            @(negedge clock);
            edges++;
            if (done) begin
                n_done++;
                if (n_done == 1) first_at = edges;
                else begin
                    second_at = edges;
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        check("b2b_first_done", 32'(first_at), 32'd6);
        check("b2b_second_done", 32'(second_at), 32'd13);
        @(negedge clock);
        check("b2b_rd_cnt", 32'(rd_cnt), 32'd7);
        check("b2b_sat_rd", 32'(s_rd_cnt), 32'd3);
        check("b2b_rdata", 32'(rdata), 32'h11);

        // Reset in the middle of ACCESS, with req, cfg_wait_en and clr_cnt held against it.
        req = 1'b1; r_wb = 1'b0; addr = 12'h456; wdata = 8'h66;
        repeat (3) @(negedge clock);
        check("rmid_cs", 32'(m_if.mem_cs), 32'd1);
        reset = 1'b1; cfg_wait_en = 1'b1; cfg_wait = 4'd9; clr_cnt = 1'b1;
        @(negedge clock);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_cs_off", 32'(m_if.mem_cs), 32'd0);
        check("rmid_we", 32'(m_if.mem_we), 32'd0);
        check("rmid_done", 32'(done), 32'd0);
        check("rmid_addr", 32'(m_if.mem_addr), 32'd0);
        check("rmid_wdata", 32'(m_if.mem_wdata), 32'd0);
        check("rmid_rdata", 32'(rdata), 32'd0);
        check("rmid_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rmid_wr_cnt", 32'(wr_cnt), 32'd0);
        reset = 1'b0; req = 1'b0; cfg_wait_en = 1'b0; clr_cnt = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("rmid_no_done", 32'(n_done), 32'd0);
        check("rmid_wr_after", 32'(wr_cnt), 32'd0);

        // Wait register back at its reset value of 2.
        run_access("rstw", 1'b1, 12'h0AA, 8'h00, 1'b0, 4'd0, 8'h77, 2, 1'b0, 1'b0);
        check("rstw_rdata", 32'(rdata), 32'h77);
        check("rstw_rd_cnt", 32'(rd_cnt), 32'd1);
        check("rstw_sat_rd", 32'(s_rd_cnt), 32'd1);

        // Clear coincident with the DONE-exit increment of a write.
        run_access("clr", 1'b0, 12'h321, 8'h99, 1'b0, 4'd0, 8'hEE, 2, 1'b0, 1'b1);
        check("clr_rd_cnt", 32'(rd_cnt), 32'd0);
        check("clr_wr_cnt", 32'(wr_cnt), 32'd0);
        check("clr_sat_rd", 32'(s_rd_cnt), 32'd0);
        check("clr_sat_wr", 32'(s_wr_cnt), 32'd0);
        check("clr_rdata", 32'(rdata), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
